prog_loader: RTL and testbench
==============================

# prog_loader

UART boot loader that writes programs into instruction memory over a host serial link. It sits beside the core, drives the write port of `inst_memory`, and holds the core in reset (`cpu_run` low) until a complete, valid image has been received. The core only ever reads instruction memory; this block is its sole writer.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz
- `BAUD`, 115200, UART bit rate; bit period `DIV = CLK_HZ/BAUD` (integer truncation, 434 at defaults)
- `ADDR_W`, 10, instruction-memory word-address width; capacity `2^ADDR_W` words
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `uart_rx`  in  1  serial input, idle high, 8N1, LSB first
- `im_we`  out  1  one-cycle instruction-memory write strobe
- `im_waddr`  out  32  byte address of the write, word aligned (`[1:0]` = 0)
- `im_wdata`  out  32  write data
- `cpu_run`  out  1  high releases the core; low holds it in reset
- `err`  out  1  sticky: last load attempt failed
- `busy`  out  1  high from header accepted to load end

## Operation
- RX front end: 2-flop synchronizer on `uart_rx`. A falling edge in RX idle starts a timer; at `DIV/2` the line is resampled and if high the start is rejected (glitch). Data bits are sampled every `DIV` clocks after that point, then the stop bit. A stop bit of 0 is a framing error: byte discarded, frame FSM goes to FAIL.
- Frame format: header `0xA5`, count N as 2 bytes little-endian, N words of 4 bytes little-endian, then a checksum byte (see Configuration).
- Frame FSM states: IDLE, CNT_LO, CNT_HI, DATA, CSUM, RUN, FAIL.
  - IDLE: bytes other than `0xA5` are ignored. `0xA5` -> CNT_LO, sets `busy`, clears `err`.
  - CNT_LO -> CNT_HI; in CNT_HI, N = 0 or N > `2^ADDR_W` -> FAIL, else -> DATA.
  - DATA: byte index 0..3 shifted into the word (byte 0 -> `[7:0]`). On the 4th byte, write word k to `im_waddr = 4*k`, k from 0. After word N-1 -> CSUM (or RUN when the checksum is compiled out).
  - CSUM: byte equal to the running XOR of all data bytes -> RUN, else -> FAIL.
  - RUN: `cpu_run`=1, `busy`=0. All UART input is ignored until `rst_n` is asserted.
  - FAIL: `err`=1, `busy`=0, `cpu_run`=0, next cycle -> IDLE. Words already written stay in memory.
- Checksum accumulator and word counter clear on header acceptance.

## Timing
- Reset values: `im_we`=0, `im_waddr`=0, `im_wdata`=0, `cpu_run`=0, `err`=0, `busy`=0, FSM=IDLE, RX idle.
- Byte-valid is produced on the cycle the stop bit is sampled; the FSM consumes it on the next edge.
- `im_we` is high for exactly one cycle, one clock after the 4th data byte's stop sample. `im_waddr`/`im_wdata` are valid in that cycle and held until the next write.
- `cpu_run` rises one clock after the final byte is consumed (checksum byte, or the last data byte when the checksum is compiled out). Once high it stays high until reset.
- Asserting `rst_n` mid-load aborts immediately: all outputs return to reset values and the partial image is not resumed.
- Total load time is `(3 + 4N + 1)` UART frames of `10*DIV` clocks each, plus at most 2 clocks.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: the CSUM state and XOR accumulator are built, and a mismatch fails the load.
- Undefined: the frame has no checksum byte; DATA goes directly to RUN after word N-1. CSUM state and accumulator are absent.

## Test plan
- Load N=2, words `0x00000013`, `0x00A00093`, correct checksum -> `im_we` pulses at `im_waddr` 0x0 then 0x4 with those data; `cpu_run`=1, `err`=0.
- Same image with checksum byte XOR `0x01` -> both writes occur, `err`=1, `cpu_run`=0, FSM in IDLE; a following correct frame then sets `cpu_run`=1.
- Junk `0x00 0xFF` before the header; N=0; and N=`2^ADDR_W`+1 -> junk ignored; both bad counts set `err`=1 with no `im_we`.
- Stop bit forced 0 on the 2nd data byte -> FAIL, `err`=1, no write for word 0; a 0.3-bit low glitch on an idle line -> no byte received.
- Assert `rst_n` low after 5 data bytes -> all outputs reset at once; a full reload afterwards succeeds starting at address 0x0.
- After `cpu_run`=1, send a new `0xA5` frame -> no `im_we`, `cpu_run` stays 1; with `PROG_LOADER_CHECKSUM_EN` undefined, the N=1 frame without a checksum byte -> `cpu_run`=1.

Source files
------------

// File: rtl/prog_loader.sv
// UART boot loader: receives a 0xA5/count/words image and writes it into instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module prog_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        im_we,
    output logic [31:0] im_waddr,
    output logic [31:0] im_wdata,
    output logic        cpu_run,
    output logic        err,
    output logic        busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam longint CAP = longint'(1) << ADDR_W;
    localparam logic [7:0] HDR = 8'hA5;

    // ---------------- RX front end ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_nxt;
    logic          rx_meta, rx_sync, rx_prev;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          half_hit, full_hit;
    logic          byte_valid, frame_err;

    assign half_hit = (tmr == T_HALF);
    assign full_hit = (tmr == T_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_nxt;
    end

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_nxt = RX_START;
            RX_START: if (half_hit) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (full_hit) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rx_state == RX_STOP && full_hit) begin
            byte_valid = rx_sync;
            frame_err  = !rx_sync;
        end
    end

    // Timer restarts at each sample point so later bits stay centred on the mid-start sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            tmr     <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (rx_state == RX_IDLE || (rx_state == RX_START && half_hit) || full_hit)
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;
            if (rx_state == RX_START)
                bit_idx <= '0;
            else if (rx_state == RX_DATA && full_hit) begin
                bit_idx <= bit_idx + 1'b1;
                rx_byte <= {rx_sync, rx_byte[7:1]};
            end
        end
    end

    // ---------------- Frame FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN, S_FAIL
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt_lo;
    logic [15:0] n_in, n_words, word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] word;
    logic        count_bad, last_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign n_in      = {rx_byte, cnt_lo};
    assign count_bad = (n_in == 16'd0) || (longint'(n_in) > CAP);
    assign last_byte = (byte_idx == 2'd3) && (word_cnt == n_words - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:  state_nxt = S_RUN;
            S_FAIL: state_nxt = S_IDLE;
            default: begin
                if (frame_err)
                    state_nxt = S_FAIL;
                else if (byte_valid) begin
                    case (state)
                        S_IDLE:   if (rx_byte == HDR) state_nxt = S_CNT_LO;
                        S_CNT_LO: state_nxt = S_CNT_HI;
                        S_CNT_HI: state_nxt = count_bad ? S_FAIL : S_DATA;
                        S_DATA: if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_nxt = S_CSUM;
`else
                            state_nxt = S_RUN;
`endif
                        end
`ifdef PROG_LOADER_CHECKSUM_EN
                        S_CSUM:   state_nxt = (rx_byte == csum) ? S_RUN : S_FAIL;
`endif
                        default:  state_nxt = state;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        cpu_run = 1'b0;
        busy    = 1'b0;
        case (state)
            S_CNT_LO, S_CNT_HI, S_DATA: busy = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: busy = 1'b1;
`endif
            S_RUN:  cpu_run = 1'b1;
            default: ;
        endcase
    end

    // Datapath: counters, word assembly and the registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we    <= 1'b0;
            im_waddr <= '0;
            im_wdata <= '0;
            err      <= 1'b0;
            cnt_lo   <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            word     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            if (state == S_IDLE && state_nxt == S_CNT_LO) begin
                err      <= 1'b0;
                word_cnt <= '0;
                byte_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == S_CNT_LO && byte_valid)
                cnt_lo <= rx_byte;
            if (state == S_CNT_HI && state_nxt == S_DATA)
                n_words <= n_in;
            if (state == S_DATA && byte_valid) begin
                byte_idx <= byte_idx + 1'b1;
                word     <= {rx_byte, word[23:8]};
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_byte;
`endif
                if (byte_idx == 2'd3) begin
                    im_we    <= 1'b1;
                    im_waddr <= {14'd0, word_cnt, 2'b00};
                    im_wdata <= {rx_byte, word};
                    word_cnt <= word_cnt + 16'd1;
                end
            end
            if (state_nxt == S_FAIL)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: serial frames in, expected memory writes queued and matched.
module tb_prog_loader;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        im_we;
    logic [31:0] im_waddr, im_wdata;
    logic        cpu_run, err, busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  run_x;
    int          wk;
    logic        we_last = 1'b0;

    prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .cpu_run(cpu_run), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            logic [63:0] e;
            chk("we_pulse", {31'd0, we_last}, 32'd0);
            if (exp_q.size() == 0)
                chk("we_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("waddr", im_waddr, e[63:32]);
                chk("wdata", im_wdata, e[31:0]);
            end
        end
        we_last <= im_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        run_x = run_x ^ b;
        send_byte(b, 1'b1);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        run_x = 8'h00;
        wk    = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input logic push);
        if (push) exp_q.push_back({32'(wk * 4), w});
        wk++;
        for (int i = 0; i < 4; i++) send_data(w[8*i +: 8]);
    endtask

    task automatic send_csum(input logic [7:0] flip);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(run_x ^ flip, 1'b1);
`else
        if (flip != 8'h00) run_x = run_x ^ flip;
`endif
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    {31'd0, im_we}, 32'd0);
        chk({tag, "_waddr"}, im_waddr, 32'd0);
        chk({tag, "_wdata"}, im_wdata, 32'd0);
        chk({tag, "_run"},   {31'd0, cpu_run}, 32'd0);
        chk({tag, "_err"},   {31'd0, err}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_status(input string tag, input logic r, input logic e, input logic b);
        chk({tag, "_run"},  {31'd0, cpu_run}, {31'd0, r});
        chk({tag, "_err"},  {31'd0, err}, {31'd0, e});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    initial begin
        logic [31:0] w;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        run_x   = 8'h00;
        wk      = 0;
        repeat (5) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);

        // Junk before header, then N=0.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        settle();
        chk_status("junk", 1'b0, 1'b0, 1'b0);
        send_hdr(16'd0);
        settle();
        chk_status("n0", 1'b0, 1'b1, 1'b0);

        // N one past capacity.
        send_hdr(16'((1 << ADDR_W) + 1));
        settle();
        chk_status("nbig", 1'b0, 1'b1, 1'b0);

        // Framing error on the second data byte.
        send_hdr(16'd2);
        chk_status("hdr_busy", 1'b0, 1'b0, 1'b1);
        send_data(8'h13);
        send_byte(8'h00, 1'b0);
        settle();
        chk_status("stop0", 1'b0, 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Corrupted checksum: writes land, load fails.
        send_hdr(16'd2);
        send_word(32'h00000013, 1'b1);
        send_word(32'h00A00093, 1'b1);
        send_csum(8'h01);
        settle();
        chk_status("badcsum", 1'b0, 1'b1, 1'b0);
`endif

        // N=1 with a short low glitch between data bytes; glitch must not become a byte.
        w = 32'hDEADBEEF;
        send_hdr(16'd1);
        exp_q.push_back({32'd0, w});
        send_data(w[7:0]);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send_data(w[15:8]);
        send_data(w[23:16]);
        send_data(w[31:24]);
        send_csum(8'h00);
        settle();
        chk_status("glitch_ok", 1'b1, 1'b0, 1'b0);

        // While running, further frames are ignored.
        send_hdr(16'd1);
        send_word(32'h12345678, 1'b0);
        send_csum(8'h00);
        settle();
        chk_status("locked", 1'b1, 1'b0, 1'b0);

        // Reset mid-load after five data bytes, then full reload.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);
        send_hdr(16'd2);
        send_word(32'hCAFEF00D, 1'b1);
        send_data(8'h55);
        chk_status("mid_busy", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);

        send_hdr(16'd2);
        send_word(32'h00000013, 1'b1);
        send_word(32'h00A00093, 1'b1);
        send_csum(8'h00);
        settle();
        chk_status("reload", 1'b1, 1'b0, 1'b0);
        chk("last_addr", im_waddr, 32'h4);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
